register_writeback: RTL and testbench
=====================================

REGISTER_WRITEBACK -- requirements
Module: register_writeback

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports named clk and reset_n as elsewhere in the codebase.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port reset_n, input, 1: asynchronous active-low reset.
REQ-004 Port ex_wb_r, input, EX_WB struct: execute-to-writeback register; fields used are alu_result[31:0], alu_result_ready, do_not_execute, reg_wr_addr[4:0], rd_wr_en.
REQ-005 Port rs1_addr, input, 5: read port A index, driven by decode.
REQ-006 Port rs2_addr, input, 5: read port B index, driven by decode.
REQ-007 Port rs1_data, output, 32: read port A data; feeds ALU operand A.
REQ-008 Port rs2_data, output, 32: read port B data; feeds ALU operand B.
REQ-009 Port wb_valid, output, 1: registered one-cycle pulse marking a committed register write.
REQ-010 Port wb_addr, output, 5: registered destination index of the last committed write.
REQ-011 Port wb_data, output, 32: registered data of the last committed write.
REQ-012 Port retired_count, output, 32: count of retired instructions.

Function
REQ-013 The block SHALL hold 31 architectural 32-bit registers, x1..x31; x0 SHALL read as 32'h0 always and SHALL never be stored.
REQ-014 The block SHALL assert an internal commit signal when alu_result_ready=1, do_not_execute=0 and rd_wr_en=1.
REQ-015 The block SHALL write alu_result into reg_wr_addr on the rising edge where commit=1 and reg_wr_addr!=0.
REQ-016 A commit with reg_wr_addr=0 SHALL leave all registers unchanged; wb_valid SHALL still pulse, with wb_addr=0 and wb_data=alu_result.
REQ-017 Reads SHALL be combinational: rsN_data = register[rsN_addr] with zero latency, x0 -> 0.
REQ-018 wb_valid, wb_addr and wb_data SHALL update one cycle after the commit edge.
REQ-019 wb_valid SHALL be 0 in every cycle without a commit; wb_addr and wb_data SHALL then hold their previous values.
REQ-020 retired_count SHALL increment by 1 on each edge where alu_result_ready=1 and do_not_execute=0, regardless of rd_wr_en.
REQ-021 retired_count SHALL wrap from 32'hFFFF_FFFF to 0 without any flag.
REQ-022 When do_not_execute=1 (a squashed instruction), the block SHALL perform no write, no wb_valid pulse and no count increment, even if rd_wr_en=1.
REQ-023 When rs1_addr equals rs2_addr, both ports SHALL return identical data in every case, including the bypass case.
REQ-024 X on alu_result SHALL NOT propagate into any register when commit=0.

Reset
REQ-025 When reset_n=0, asynchronously, the block SHALL clear x1..x31 to 0, wb_valid to 0, wb_addr to 0, wb_data to 0 and retired_count to 0.
REQ-026 A commit coinciding with an asserted reset SHALL be discarded.
REQ-027 Normal operation SHALL resume on the first rising edge after reset_n deasserts.
REQ-028 Read outputs SHALL return 0 for every index while reset is asserted.

Configuration
REQ-029 Macro WB_BYPASS_EN SHALL control same-cycle write-to-read forwarding.
- Defined: when commit=1, reg_wr_addr!=0 and reg_wr_addr==rsN_addr, rsN_data SHALL equal the incoming alu_result in that same cycle.
- Undefined: rsN_data SHALL return the stored, pre-write value until the next cycle.
REQ-030 x0 SHALL never be bypassed, in either configuration.

Verification
REQ-031 Scenario, write then read: commit x5<=32'hDEAD_BEEF; next cycle rs1_addr=5 -> rs1_data=32'hDEAD_BEEF; wb_valid=1, wb_addr=5; retired_count=1.
REQ-032 Scenario, x0 protection: commit x0<=32'h1234; rs1_addr=rs2_addr=0 -> both ports read 0; wb_valid pulses with wb_addr=0.
REQ-033 Scenario, squash: do_not_execute=1, rd_wr_en=1, x7<=32'h55 -> x7 unchanged, wb_valid=0, retired_count unchanged.
REQ-034 Scenario, bypass: commit x3<=32'hA5A5_A5A5 while rs1_addr=rs2_addr=3 in the same cycle -> both ports read A5A5_A5A5 with WB_BYPASS_EN defined, or the old x3 value without it.
REQ-035 Scenario, counter wrap: preload retired_count to 32'hFFFF_FFFF by forced stimulus, then one retire with rd_wr_en=0 -> retired_count=0 and no register write.
REQ-036 Scenario, reset mid-run: write x9=32'h1, then pulse reset_n low between edges -> x9, wb_*, retired_count all read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_writeback_if.sv
// register_writeback_if: execute-to-writeback bundle, register read ports and writeback/retire status
interface register_writeback_if;
  typedef struct packed {
    logic [31:0] alu_result;
    logic        alu_result_ready;
    logic        do_not_execute;
    logic [4:0]  reg_wr_addr;
    logic        rd_wr_en;
  } ex_wb_t;
  ex_wb_t      ex_wb_r;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retired_count;
  modport master (
    output ex_wb_r, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_valid, wb_addr, wb_data, retired_count
  );
  modport slave (
    input  ex_wb_r, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_valid, wb_addr, wb_data, retired_count
  );
endinterface

// File: rtl/register_writeback.sv
// register_writeback: x1..x31 register file, writeback commit and retire counter; WB_BYPASS_EN enables same-cycle forwarding
module register_writeback (
  input logic                  clk,
  input logic                  reset_n,
  register_writeback_if.slave  bus
);
  logic [31:0] regs [1:31];
  logic [31:0] count_q;
  logic        retire;
  logic        commit;
  logic        wr;
  // reset_n gating discards any commit that coincides with reset
  assign retire = reset_n && bus.ex_wb_r.alu_result_ready && !bus.ex_wb_r.do_not_execute;
  assign commit = retire && bus.ex_wb_r.rd_wr_en;
  assign wr     = commit && (bus.ex_wb_r.reg_wr_addr != 5'd0);
  assign bus.retired_count = count_q;
  function automatic logic [31:0] rd(input logic [4:0] a);
    logic [31:0] s;
    s = (a == 5'd0 || !reset_n) ? 32'h0 : regs[a];
`ifdef WB_BYPASS_EN
    return (wr && a == bus.ex_wb_r.reg_wr_addr) ? bus.ex_wb_r.alu_result : s;
`else
    return s;
`endif
  endfunction
  always_comb begin
    bus.rs1_data = rd(bus.rs1_addr);
    bus.rs2_data = rd(bus.rs2_addr);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_addr  <= '0;
      bus.wb_data  <= '0;
      count_q      <= '0;
    end else begin
      if (wr) regs[bus.ex_wb_r.reg_wr_addr] <= bus.ex_wb_r.alu_result;
      bus.wb_valid <= commit;
      if (commit) begin
        bus.wb_addr <= bus.ex_wb_r.reg_wr_addr;
        bus.wb_data <= bus.ex_wb_r.alu_result;
      end
      if (retire) count_q <= count_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_register_writeback.sv
// tb_register_writeback: directed scoreboard bench for register_writeback
module tb_register_writeback;
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          errors = 0;
  int          checks = 0;
  wb_t         sb[$];
  logic [31:0] exp_regs [0:31];
  logic [31:0] exp_cnt;
  logic [4:0]  last_a;
  logic [31:0] last_d;
  logic        pend;
  logic [4:0]  pend_a;
  logic [31:0] pend_d;
  logic [31:0] byp;
  register_writeback_if ifc ();
  register_writeback dut (.clk(clk), .reset_n(reset_n), .bus(ifc.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    exp_cnt = '0;
    last_a = '0;
    last_d = '0;
    pend = 1'b0;
    sb.delete();
  endtask
  task automatic drive(input logic rdy, input logic dne, input logic we, input logic [4:0] a, input logic [31:0] d);
    ifc.ex_wb_r.alu_result_ready = rdy;
    ifc.ex_wb_r.do_not_execute = dne;
    ifc.ex_wb_r.rd_wr_en = we;
    ifc.ex_wb_r.reg_wr_addr = a;
    ifc.ex_wb_r.alu_result = d;
    if (reset_n && rdy && !dne) begin
      exp_cnt = exp_cnt + 32'd1;
      if (we) begin
        sb.push_back({a, d});
        pend = (a != 5'd0);
        pend_a = a;
        pend_d = d;
      end
    end
  endtask
  task automatic tick();
    wb_t e;
    @(posedge clk);
    #1;
    if (pend) exp_regs[pend_a] = pend_d;
    pend = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      last_a = e.a;
      last_d = e.d;
      chk("wb_valid", {31'b0, ifc.wb_valid}, 32'd1);
    end else begin
      chk("wb_valid_idle", {31'b0, ifc.wb_valid}, 32'd0);
    end
    chk("wb_addr", {27'b0, ifc.wb_addr}, {27'b0, last_a});
    chk("wb_data", ifc.wb_data, last_d);
    chk("retired_count", ifc.retired_count, exp_cnt);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask
  task automatic rd_chk(input logic [4:0] a1, input logic [4:0] a2);
    ifc.rs1_addr = a1;
    ifc.rs2_addr = a2;
    #1;
    chk("rs1_data", ifc.rs1_data, exp_regs[a1]);
    chk("rs2_data", ifc.rs2_data, exp_regs[a2]);
  endtask
  initial begin
    model_reset();
    ifc.rs1_addr = 5'd0;
    ifc.rs2_addr = 5'd0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("rst_wb_valid", {31'b0, ifc.wb_valid}, 32'd0);
    chk("rst_wb_addr", {27'b0, ifc.wb_addr}, 32'd0);
    chk("rst_wb_data", ifc.wb_data, 32'd0);
    chk("rst_count", ifc.retired_count, 32'd0);
    rd_chk(5'd5, 5'd31);
    @(negedge clk);
    reset_n = 1'b1;
    // write then read
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    rd_chk(5'd5, 5'd5);
    tick();
    // x0 protection
    drive(1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
    tick();
    rd_chk(5'd0, 5'd0);
    // squash
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_0055);
    tick();
    rd_chk(5'd7, 5'd5);
    // bypass
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h1111_2222);
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5);
    ifc.rs1_addr = 5'd3;
    ifc.rs2_addr = 5'd3;
    #1;
`ifdef WB_BYPASS_EN
    byp = 32'hA5A5_A5A5;
`else
    byp = 32'h1111_2222;
`endif
    chk("byp_rs1", ifc.rs1_data, byp);
    chk("byp_rs2", ifc.rs2_data, byp);
    tick();
    rd_chk(5'd3, 5'd3);
    // retire without write
    drive(1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0099);
    tick();
    rd_chk(5'd8, 5'd3);
    // X data with no commit
    drive(1'b0, 1'b0, 1'b1, 5'd4, 32'hx);
    tick();
    rd_chk(5'd4, 5'd5);
    // counter wrap
    @(negedge clk);
    dut.count_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b0, 5'd6, 32'h0000_0077);
    tick();
    rd_chk(5'd6, 5'd6);
    // async reset mid-cycle
    drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0001);
    tick();
    rd_chk(5'd9, 5'd5);
    reset_n = 1'b0;
    model_reset();
    rd_chk(5'd9, 5'd5);
    chk("arst_wb_valid", {31'b0, ifc.wb_valid}, 32'd0);
    chk("arst_wb_addr", {27'b0, ifc.wb_addr}, 32'd0);
    chk("arst_wb_data", ifc.wb_data, 32'd0);
    chk("arst_count", ifc.retired_count, 32'd0);
    // commit during reset is discarded
    drive(1'b1, 1'b0, 1'b1, 5'd10, 32'hCAFE_0001);
    tick();
    rd_chk(5'd10, 5'd10);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 5'd10, 32'hCAFE_0002);
    tick();
    rd_chk(5'd10, 5'd9);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
